// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU types and constants (divider FSM states, saturation).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam logic [15:0] SAT_POS    = 16'h7FFF;
  localparam logic [15:0] SAT_NEG    = 16'h8000;
  localparam int          DIV_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/div_step_17bit.sv
// ============================================================================
// Module   : div_step_17bit
// Purpose  : One combinational restoring-division step (shift, trial subtract).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step_17bit (
  input  logic [16:0] rem_in,
  input  logic [15:0] divisor,
  input  logic        dividend_bit,
  output logic [16:0] rem_out,
  output logic        q_bit
);

  logic [17:0] w_shifted;
  logic [17:0] w_trial;

  // One spare bit above the shifted remainder so the trial sign is never aliased.
  assign w_shifted = {rem_in, dividend_bit};
  assign w_trial   = w_shifted - {2'b00, divisor};
  assign q_bit     = ~w_trial[17];
  assign rem_out   = w_trial[17] ? w_shifted[16:0] : w_trial[16:0];

endmodule

`default_nettype wire

// File: rtl/sat_div_16bit.sv
// ============================================================================
// Module   : sat_div_16bit
// Purpose  : Fixed-latency 16-bit signed divider with saturation and flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_div_16bit #(
  parameter int DIV_CYCLES = alu_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Quot,
  output logic [15:0] Rem,
  output logic        Ovfl,
  output logic        DivZero
);

  import alu_pkg::*;

  localparam int                  c_cnt_w = $clog2(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DIV_CYCLES - 1);

  div_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [16:0]        r_rem;
  logic [15:0]        r_q;
  logic [15:0]        r_abs_b;
  logic [15:0]        r_a;
  logic               r_sq;
  logic               r_sr;
  logic               r_dz;
  logic               r_ov;

  logic [15:0]        w_abs_a;
  logic [15:0]        w_abs_b;
  logic [16:0]        w_rem_next;
  logic               w_q_bit;
  logic [15:0]        w_quot_signed;
  logic [15:0]        w_rem_signed;

  // Magnitude of 0x8000 wraps back to 0x8000, which is the correct unsigned value.
  assign w_abs_a = A[15] ? (16'd0 - A) : A;
  assign w_abs_b = B[15] ? (16'd0 - B) : B;

  div_step_17bit u_step (
    .rem_in       (r_rem),
    .divisor      (r_abs_b),
    .dividend_bit (r_q[15]),
    .rem_out      (w_rem_next),
    .q_bit        (w_q_bit)
  );

  assign w_quot_signed = r_sq ? (16'd0 - r_q) : r_q;
  assign w_rem_signed  = r_sr ? (16'd0 - r_rem[15:0]) : r_rem[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_abs_b <= '0;
      r_a     <= '0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Quot    <= '0;
      Rem     <= '0;
      Ovfl    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (r_state == RUN);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q     <= w_abs_a;
            r_abs_b <= w_abs_b;
            r_a     <= A;
            r_sq    <= A[15] ^ B[15];
            r_sr    <= A[15];
            r_dz    <= (B == 16'h0000);
            r_ov    <= (A == 16'h8000) && (B == 16'hFFFF);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[14:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          done    <= 1'b1;
          DivZero <= r_dz;
          // Special cases discard whatever the iteration produced.
          if (r_dz) begin
            Quot <= r_sr ? SAT_NEG : SAT_POS;
            Rem  <= r_a;
            Ovfl <= 1'b0;
          end else if (r_ov) begin
            Quot <= SAT_POS;
            Rem  <= 16'h0000;
            Ovfl <= 1'b1;
          end else begin
            Quot <= w_quot_signed;
            Rem  <= w_rem_signed;
            Ovfl <= 1'b0;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
